alu_fp_chain: RTL and testbench

- Sequential multi-byte add/subtract engine for unsigned fixed-point operands.
- Operands are BYTES bytes wide, with the binary point between bits 3 and 4 (4 fractional bits).
- Processes one byte per clock, LSB byte first, through an internal 8-bit add/sub slice. The slice's carry/borrow out feeds the next byte's carry/borrow in.
- Drives the narrow ALU interface (cin/cout chaining) from the initiator side, so the datapath can handle words wider than 8 bits.

---
 rtl/alu_fp_chain.sv | 114 +++++++++++
 tb/tb_alu_fp_chain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fp_chain.sv
// alu_fp_chain: byte-serial add/subtract engine for unsigned fixed-point
// operands (4 fractional bits). One 8-bit slice is evaluated per clock,
// LSB byte first, with the slice carry/borrow chained into the next byte.
module alu_fp_chain #(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           opcode,
  input  logic                 cin,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [8*BYTES-1:0]   result,
  output logic                 cout
);

  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [W-1:0]    a_q, b_q;
  logic [1:0]      op_q;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            last;
  logic [7:0]      xa, xb;
  logic [8:0]      sum;
  logic [W-1:0]    res_n;

  // One 8-bit add/sub slice; bit 8 is carry (add) or borrow (subtract).
  function automatic logic [8:0] slice(input logic [1:0] op, input logic [7:0] x,
                                       input logic [7:0] y, input logic c);
    logic [8:0] r;
    case (op)
      2'b00:   r = {1'b0, x} + {1'b0, y} + {8'b0, c};
      2'b01:   r = {1'b0, x} - {1'b0, y} - {8'b0, c};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign last = (idx == IW'(BYTES - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: DONE lasts exactly one cycle, start only seen in IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Select the current byte pair, evaluate the slice, and merge it into the result.
  always_comb begin
    xa = '0;
    xb = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (idx == k[IW-1:0]) begin
        xa = a_q[8*k +: 8];
        xb = b_q[8*k +: 8];
      end
    end
    sum   = slice(op_q, xa, xb, carry);
    res_n = result;
    for (int k = 0; k < BYTES; k++) begin
      if (idx == k[IW-1:0]) res_n[8*k +: 8] = sum[7:0];
    end
  end

  // Operand capture on accept, then one byte written per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          op_q   <= opcode;
          carry  <= cin;
          idx    <= '0;
          result <= '0;
          cout   <= 1'b0;
        end
        RUN: begin
          result <= res_n;
          carry  <= sum[8];
          idx    <= idx + 1'b1;
          if (last) cout <= sum[8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_fp_chain.sv
// Bench for alu_fp_chain: three instances (1, 2 and 4 bytes) share one
// stimulus stream and are compared against a whole-word arithmetic model.
module tb_alu_fp_chain;

  logic        clk = 1'b0;
  logic        rst, start, ci;
  logic [1:0]  op;
  logic [31:0] opa, opb;

  logic        busy1, done1, cout1;
  logic [7:0]  res1;
  logic        busy2, done2, cout2;
  logic [15:0] res2;
  logic        busy4, done4, cout4;
  logic [31:0] res4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_fp_chain #(.BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .opcode(op), .cin(ci),
    .a(opa[7:0]), .b(opb[7:0]), .busy(busy1), .done(done1), .result(res1), .cout(cout1));

  alu_fp_chain #(.BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .opcode(op), .cin(ci),
    .a(opa[15:0]), .b(opb[15:0]), .busy(busy2), .done(done2), .result(res2), .cout(cout2));

  alu_fp_chain #(.BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .opcode(op), .cin(ci),
    .a(opa), .b(opb), .busy(busy4), .done(done4), .result(res4), .cout(cout4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int nb);
    case (nb)
      1:       return busy1;
      2:       return busy2;
      default: return busy4;
    endcase
  endfunction

  function automatic logic get_done(input int nb);
    case (nb)
      1:       return done1;
      2:       return done2;
      default: return done4;
    endcase
  endfunction

  function automatic logic get_cout(input int nb);
    case (nb)
      1:       return cout1;
      2:       return cout2;
      default: return cout4;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int nb);
    case (nb)
      1:       return {24'b0, res1};
      2:       return {16'b0, res2};
      default: return res4;
    endcase
  endfunction

  // Whole-word reference: {cout, result} for an nb-byte operand width.
  function automatic logic [32:0] ref_op(input int nb, input logic [1:0] o, input logic c,
                                         input logic [31:0] x, input logic [31:0] y);
    longint unsigned m, xa, ya, s;
    logic [32:0] r;
    m  = (64'd1 << (8 * nb)) - 64'd1;
    xa = longint'(x) & m;
    ya = longint'(y) & m;
    case (o)
      2'd0: begin
        s = xa + ya + longint'(c);
        r = {(s > m), 32'(s & m)};
      end
      2'd1: begin
        s = (xa - ya - longint'(c)) & m;
        r = {(xa < ya + longint'(c)), 32'(s)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // One operation on all three widths, checking busy/done each cycle and the final result.
  task automatic run_op(input string name, input logic [1:0] o, input logic c,
                        input logic [31:0] x, input logic [31:0] y);
    logic [32:0] e;
    op = o; ci = c; opa = x; opb = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa = $urandom; opb = $urandom; op = 2'($urandom); ci = 1'($urandom);
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      for (int nb = 1; nb <= 4; nb *= 2) begin
        check($sformatf("%s.b%0d.busy.c%0d", name, nb, cyc), 64'(get_busy(nb)), 64'(cyc < nb));
        check($sformatf("%s.b%0d.done.c%0d", name, nb, cyc), 64'(get_done(nb)), 64'(cyc == nb));
        if (cyc >= nb) begin
          e = ref_op(nb, o, c, x, y);
          check($sformatf("%s.b%0d.result.c%0d", name, nb, cyc), 64'(get_res(nb)), 64'(e[31:0]));
          check($sformatf("%s.b%0d.cout.c%0d", name, nb, cyc), 64'(get_cout(nb)), 64'(e[32]));
        end
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] x, y;
    logic [1:0]  o;
    logic        c;
    logic [32:0] e;

    // Reset, with start asserted to confirm reset wins
    rst = 1'b1; start = 1'b1; op = 2'd0; ci = 1'b0; opa = 32'h78; opb = 32'h24;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    for (int nb = 1; nb <= 4; nb *= 2) begin
      check($sformatf("rst.b%0d.busy", nb), 64'(get_busy(nb)), 64'd0);
      check($sformatf("rst.b%0d.done", nb), 64'(get_done(nb)), 64'd0);
      check($sformatf("rst.b%0d.result", nb), 64'(get_res(nb)), 64'd0);
      check($sformatf("rst.b%0d.cout", nb), 64'(get_cout(nb)), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic add/sub with and without cin
    run_op("add",      2'd0, 1'b0, 32'h0000_0078, 32'h0000_0024);
    run_op("sub",      2'd1, 1'b0, 32'h0000_0078, 32'h0000_0024);
    run_op("sub_cin",  2'd1, 1'b1, 32'h0000_0078, 32'h0000_0024);
    run_op("add_cin",  2'd0, 1'b1, 32'h0000_0078, 32'h0000_0024);
    // Inter-byte chaining
    run_op("chain_a",  2'd0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
    run_op("chain_b",  2'd0, 1'b0, 32'h0000_FFFF, 32'h0000_0001);
    run_op("chain_c",  2'd1, 1'b0, 32'h0000_0000, 32'h0000_0001);
    run_op("chain_d",  2'd1, 1'b0, 32'h0000_0100, 32'h0000_0001);
    run_op("chain_e",  2'd0, 1'b0, 32'h00FF_FFFF, 32'h0000_0001);
    run_op("chain_f",  2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    // Reserved opcodes
    run_op("rsv10",    2'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("rsv11",    2'd3, 1'b0, 32'h1234_5678, 32'h0000_0001);

    // Starts during RUN and DONE are ignored (2-byte instance)
    op = 2'd0; ci = 1'b0; opa = 32'h78; opb = 32'h24; start = 1'b1;
    @(posedge clk); #1;
    opa = 32'h1111; opb = 32'h2222; op = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("hs.busy_run", 64'(busy2), 64'd1);
    @(posedge clk); #1;
    check("hs.done", 64'(done2), 64'd1);
    check("hs.result", 64'(res2), 64'h009C);
    check("hs.cout", 64'(cout2), 64'd0);
    start = 1'b1; opa = 32'h5555; opb = 32'h3333;
    @(posedge clk); #1;
    start = 1'b0;
    check("hs.done_off", 64'(done2), 64'd0);
    check("hs.busy_off", 64'(busy2), 64'd0);
    check("hs.result_hold", 64'(res2), 64'h009C);
    @(posedge clk); #1;
    check("hs.idle", 64'(busy2), 64'd0);
    check("hs.result_hold2", 64'(res2), 64'h009C);
    pulse_reset();

    // Start held high: accepted every BYTES+2 cycles on the 2-byte instance
    for (int n = 0; n < 4; n++) begin
      x = $urandom; y = $urandom; o = 2'($urandom_range(0, 1)); c = 1'($urandom);
      op = o; ci = c; opa = x; opb = y; start = 1'b1;
      @(posedge clk); #1;
      check($sformatf("held%0d.busy0", n), 64'(busy2), 64'd1);
      opa = $urandom; opb = $urandom; op = 2'($urandom); ci = 1'($urandom);
      @(posedge clk); #1;
      check($sformatf("held%0d.busy1", n), 64'(busy2), 64'd1);
      check($sformatf("held%0d.done1", n), 64'(done2), 64'd0);
      @(posedge clk); #1;
      e = ref_op(2, o, c, x, y);
      check($sformatf("held%0d.done", n), 64'(done2), 64'd1);
      check($sformatf("held%0d.result", n), 64'(res2), 64'(e[15:0]));
      check($sformatf("held%0d.cout", n), 64'(cout2), 64'(e[32]));
      @(posedge clk); #1;
      check($sformatf("held%0d.done_off", n), 64'(done2), 64'd0);
      check($sformatf("held%0d.busy_off", n), 64'(busy2), 64'd0);
    end
    start = 1'b0;
    pulse_reset();

    // Reset mid-operation aborts without a done pulse
    op = 2'd0; ci = 1'b0; opa = 32'h0000_1234; opb = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int nb = 1; nb <= 4; nb *= 2) begin
      check($sformatf("abort.b%0d.busy", nb), 64'(get_busy(nb)), 64'd0);
      check($sformatf("abort.b%0d.done", nb), 64'(get_done(nb)), 64'd0);
      check($sformatf("abort.b%0d.result", nb), 64'(get_res(nb)), 64'd0);
      check($sformatf("abort.b%0d.cout", nb), 64'(get_cout(nb)), 64'd0);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      check($sformatf("abort.nodone.c%0d", cyc), 64'(done2), 64'd0);
      check($sformatf("abort.nobusy.c%0d", cyc), 64'(busy2), 64'd0);
    end
    run_op("after_abort", 2'd0, 1'b0, 32'h0000_1234, 32'h0000_0001);

    // Randomized operations on all widths
    for (int n = 0; n < 20; n++) begin
      run_op($sformatf("rnd%0d", n), 2'($urandom), 1'($urandom), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
